// File: rtl/unary_pkg.sv
// Shared types and defaults for the unary multiplier scheduler.
package unary_pkg;

  localparam int DEFAULT_INPUT_WIDTH = 32;
  localparam int DEFAULT_NUM_REQ     = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    SETTLE,
    DONE
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  int          w_cand;
  logic [IW-1:0] w_cand_idx;

  always_comb begin
    o_gnt      = '0;
    o_idx      = '0;
    o_valid    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // Wrap explicitly so non-power-of-two counts go NUM_REQ-1 -> 0.
      w_cand = int'(i_ptr) + off;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      w_cand_idx = IW'(w_cand);
      if (!o_valid && i_req[w_cand_idx]) begin
        o_valid           = 1'b1;
        o_idx             = w_cand_idx;
        o_gnt[w_cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unary_mul_scheduler.sv
// Time-multiplexes one unary multiplier among NUM_REQ requesters: grant, clear, feed W bits,
// settle, report the collected output bitstream.
module unary_mul_scheduler
  import unary_pkg::*;
#(
  parameter int NUM_REQ     = DEFAULT_NUM_REQ,
  parameter int INPUT_WIDTH = DEFAULT_INPUT_WIDTH,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] a_vec,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] b_vec,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic [INPUT_WIDTH-1:0]         res_vec,
  output logic [COUNT_WIDTH-1:0]         res_len,
  output logic                           busy,
  output logic                           mul_rst_n,
  output logic [1:0]                     mul_ready,
  output logic                           mul_a,
  output logic                           mul_b,
  input  logic                           mul_valid,
  input  logic                           mul_y,
  output sched_state_e                   o_dbg_state
);

  localparam int W  = INPUT_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (W > 1) ? $clog2(W) : 1;
  localparam logic [COUNT_WIDTH-1:0] LAST_FEED = COUNT_WIDTH'(W - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL      = COUNT_WIDTH'(W);

  sched_state_e           r_state;
  sched_state_e           w_next;
  logic [IW-1:0]          r_ptr;
  logic [IW-1:0]          r_owner;
  logic [W-1:0]           r_sh_a;
  logic [W-1:0]           r_sh_b;
  logic [COUNT_WIDTH-1:0] r_feed_cnt;
  logic [NUM_REQ-1:0]     w_arb_gnt;
  logic [IW-1:0]          w_arb_idx;
  logic                   w_arb_valid;
  logic                   w_capture;
  logic [SW-1:0]          w_cap_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_arb_valid) w_next = CLEAR;
      CLEAR:   w_next = FEED;
      FEED:    if (r_feed_cnt == LAST_FEED) w_next = SETTLE;
      SETTLE:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The multiplier answers one cycle after each fed bit, so the first FEED cycle
  // still shows post-reset junk and SETTLE carries the answer to the last bit.
  assign w_capture = mul_valid && (res_len < FULL) &&
                     (((r_state == FEED) && (r_feed_cnt != '0)) || (r_state == SETTLE));
  assign w_cap_idx = res_len[SW-1:0];
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt        <= '0;
      done       <= '0;
      res_vec    <= '0;
      res_len    <= '0;
      busy       <= 1'b0;
      mul_rst_n  <= 1'b0;
      mul_ready  <= 2'b00;
      mul_a      <= 1'b0;
      mul_b      <= 1'b0;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_sh_a     <= '0;
      r_sh_b     <= '0;
      r_feed_cnt <= '0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      // Multiplier-facing outputs are loaded from the next state so they line up
      // with the state they belong to.
      busy      <= (w_next != IDLE);
      mul_rst_n <= (w_next != CLEAR);
      mul_ready <= (w_next == FEED) ? 2'b11 : 2'b00;
      mul_a     <= 1'b0;
      mul_b     <= 1'b0;
      if (w_next == FEED) begin
        mul_a  <= r_sh_a[0];
        mul_b  <= r_sh_b[0];
        r_sh_a <= r_sh_a >> 1;
        r_sh_b <= r_sh_b >> 1;
      end
      case (r_state)
        IDLE: if (w_arb_valid) begin
          gnt     <= w_arb_gnt;
          r_owner <= w_arb_idx;
          r_ptr   <= (w_arb_idx == IW'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
          r_sh_a  <= a_vec[w_arb_idx*W +: W];
          r_sh_b  <= b_vec[w_arb_idx*W +: W];
        end
        CLEAR: begin
          res_vec    <= '0;
          res_len    <= '0;
          r_feed_cnt <= '0;
        end
        FEED:    r_feed_cnt <= r_feed_cnt + 1'b1;
        DONE:    done[r_owner] <= 1'b1;
        default: ;
      endcase
      if (w_capture) begin
        res_vec[w_cap_idx] <= mul_y;
        res_len            <= res_len + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_unary_mul_scheduler.sv
// Bench for unary_mul_scheduler with a stand-in multiplier that emits a&b only when a==b.
module tb_unary_mul_scheduler;
  import unary_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = $clog2(W + 1);

  logic             clk;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_vec;
  logic [N*W-1:0]   b_vec;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic [W-1:0]     res_vec;
  logic [CW-1:0]    res_len;
  logic             busy;
  logic             mul_rst_n;
  logic [1:0]       mul_ready;
  logic             mul_a;
  logic             mul_b;
  logic             mul_valid;
  logic             mul_y;
  sched_state_e     dbg_state;

  unary_mul_scheduler #(.NUM_REQ(N), .INPUT_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .a_vec(a_vec), .b_vec(b_vec),
    .gnt(gnt), .done(done), .res_vec(res_vec), .res_len(res_len), .busy(busy),
    .mul_rst_n(mul_rst_n), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid(mul_valid), .mul_y(mul_y), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in multiplier: output is garbage unless out of reset and both lanes ready.
  always @(posedge clk) begin
    if (mul_rst_n && mul_ready == 2'b11) begin
      mul_valid <= (mul_a == mul_b);
      mul_y     <= mul_a & mul_b;
    end else begin
      mul_valid <= 1'($urandom_range(1, 0));
      mul_y     <= 1'($urandom_range(1, 0));
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic void ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] v, output int len);
    v   = '0;
    len = 0;
    for (int k = 0; k < W; k++) begin
      if (a[k] == b[k]) begin
        v[len] = a[k] & b[k];
        len++;
      end
    end
  endfunction

  // Scoreboard
  logic [W-1:0]   exp_q[$];
  int             exp_len_q[$];
  int             exp_idx_q[$];
  int             exp_cyc_q[$];
  logic [N-1:0]   gnt_vec_log[$];
  int             gnt_cyc_log[$];
  int             done_cyc_log[$];
  int             cyc = 0;
  int             gnt_cnt = 0;
  int             done_cnt = 0;
  int             model_ptr = 0;
  int             m_pick;
  int             m_len;
  logic [W-1:0]   m_vec;
  logic [N-1:0]   prev_req = '0;
  logic [N*W-1:0] prev_a = '0;
  logic [N*W-1:0] prev_b = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      model_ptr = 0;
      exp_q.delete();
      exp_len_q.delete();
      exp_idx_q.delete();
      exp_cyc_q.delete();
      prev_req = '0;
    end else begin
      check("gnt_onehot", 64'($onehot0(gnt)), 64'd1);
      check("done_onehot", 64'($onehot0(done)), 64'd1);
      check("gnt_done_excl", 64'((|gnt) && (|done)), 64'd0);
      m_pick = (exp_q.size() == 0) ? rr_pick(prev_req, model_ptr) : -1;
      check("gnt_vec", 64'(gnt), (m_pick < 0) ? 64'd0 : (64'd1 << m_pick));
      if (m_pick >= 0) begin
        ref_mul(prev_a[m_pick*W +: W], prev_b[m_pick*W +: W], m_vec, m_len);
        exp_q.push_back(m_vec);
        exp_len_q.push_back(m_len);
        exp_idx_q.push_back(m_pick);
        exp_cyc_q.push_back(cyc + W + 3);
        model_ptr = (m_pick + 1) % N;
      end
      if (|gnt) begin
        gnt_cnt++;
        gnt_vec_log.push_back(gnt);
        gnt_cyc_log.push_back(cyc);
      end
      if (|done) begin
        done_cnt++;
        done_cyc_log.push_back(cyc);
      end
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        check("done_vec", 64'(done), 64'd1 << exp_idx_q[0]);
        check("res_vec", 64'(res_vec), 64'(exp_q[0]));
        check("res_len", 64'(res_len), 64'(exp_len_q[0]));
        void'(exp_q.pop_front());
        void'(exp_len_q.pop_front());
        void'(exp_idx_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else begin
        check("done_quiet", 64'(done), 64'd0);
      end
      prev_req = req;
    end
    prev_a = a_vec;
    prev_b = b_vec;
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_job(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    a_vec[i*W +: W] = a;
    b_vec[i*W +: W] = b;
    req[i] = 1'b1;
  endtask

  task automatic set_req(input logic [N-1:0] r);
    @(posedge clk);
    #1;
    req = r;
  endtask

  task automatic wait_gnt_cnt(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && gnt_cnt < target; k++) tick();
    check(tag, 64'(gnt_cnt), 64'(target));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int k = 0; k < budget && (exp_q.size() != 0 || busy); k++) tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_gnt"}, 64'(gnt), 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_res_vec"}, 64'(res_vec), 64'd0);
    check({pfx, "_res_len"}, 64'(res_len), 64'd0);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_mul_rst_n"}, 64'(mul_rst_n), 64'd0);
    check({pfx, "_mul_ready"}, 64'(mul_ready), 64'd0);
    check({pfx, "_mul_ab"}, 64'({mul_a, mul_b}), 64'd0);
    check({pfx, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  logic [N-1:0] rr_exp [5];
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  int           base;
  int           snap;

  initial begin
    reset = 1'b0;
    req   = '0;
    a_vec = '0;
    b_vec = '0;
    repeat (3) tick();
    check_reset_vals("reset");

    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    tick();
    check("idle_mul_rst_n", 64'(mul_rst_n), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // Single job, all ones
    drive_job(0, '1, '1);
    tick();
    check("single_gnt_wait", 64'(gnt), 64'd0);
    tick();
    check("single_gnt", 64'(gnt), 64'b0001);
    check("clear_mul_rst_n", 64'(mul_rst_n), 64'd0);
    check("clear_busy", 64'(busy), 64'd1);
    tick();
    check("feed_ready", 64'(mul_ready), 64'd3);
    check("feed_mul_rst_n", 64'(mul_rst_n), 64'd1);
    check("feed_ab", 64'({mul_a, mul_b}), 64'd3);
    set_req('0);
    wait_drain("single_drain", 100);
    check("single_res_len", 64'(res_len), 64'd32);
    check("single_res_vec", 64'(res_vec), 64'hFFFF_FFFF);
    check("single_latency", 64'(done_cyc_log[$] - gnt_cyc_log[$]), 64'd35);

    // Zero operand on requester 1
    drive_job(1, '0, '1);
    wait_gnt_cnt("zero_gnt", 2, 10);
    set_req('0);
    wait_drain("zero_drain", 100);
    check("zero_res_vec", 64'(res_vec), 64'd0);
    check("zero_res_len", 64'(res_len), 64'd0);
    check("zero_latency", 64'(done_cyc_log[$] - gnt_cyc_log[$]), 64'(W + 3));

    // Tie pattern: only half the bit positions agree
    drive_job(2, 32'h5555_5555, 32'h3333_3333);
    wait_gnt_cnt("tie_gnt", 3, 10);
    set_req('0);
    wait_drain("tie_drain", 100);
    check("tie_res_len", 64'(res_len), 64'd16);
    check("tie_res_vec", 64'(res_vec), 64'h0000_5555);

    // Pointer now at 3: req 0101 must wrap to 0, then 2
    base = gnt_cnt;
    @(posedge clk);
    #1;
    a_vec = {$urandom, $urandom, $urandom, $urandom};
    b_vec = {$urandom, $urandom, $urandom, $urandom};
    req   = 4'b0101;
    wait_gnt_cnt("wrap_gnt", base + 2, 2 * (W + 4) + 10);
    set_req('0);
    check("wrap_first", 64'(gnt_vec_log[base]), 64'b0001);
    check("wrap_second", 64'(gnt_vec_log[base + 1]), 64'b0100);
    wait_drain("wrap_drain", 100);

    // All requesters held: round-robin from pointer 3
    rr_exp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    base = gnt_cnt;
    set_req(4'b1111);
    wait_gnt_cnt("rr_gnt", base + 5, 5 * (W + 4) + 10);
    set_req('0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_order%0d", k), 64'(gnt_vec_log[base + k]), 64'(rr_exp[k]));
      if (k > 0)
        check($sformatf("rr_spacing%0d", k),
              64'(gnt_cyc_log[base + k] - gnt_cyc_log[base + k - 1]), 64'(W + 4));
    end
    wait_drain("rr_drain", 100);

    // Randomized traffic, including requests that come and go while busy
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        req[i] = ($urandom_range(5, 0) == 0);
        ra = $urandom;
        rb = ($urandom_range(1, 0) == 1) ? (ra ^ ($urandom & $urandom & $urandom)) : $urandom;
        a_vec[i*W +: W] = ra;
        b_vec[i*W +: W] = rb;
      end
    end
    set_req('0);
    wait_drain("rand_drain", 100);
    check("rand_activity", 64'(gnt_cnt > base + 10), 64'd1);

    // Abort mid-FEED with asynchronous reset
    base = gnt_cnt;
    drive_job(1, $urandom, $urandom);
    wait_gnt_cnt("abort_gnt", base + 1, 10);
    set_req('0);
    repeat (9) tick();
    check("abort_pre_state", 64'(dbg_state), 64'(FEED));
    snap = done_cnt;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (3) tick();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (W + 10) tick();
    check("abort_no_done", 64'(done_cnt), 64'(snap));
    check("abort_idle", 64'(busy), 64'd0);

    // Restart after abort: pointer back at 0, requester 2 still wins
    ra = $urandom;
    rb = ra ^ 32'h0F0F_0000;
    ref_mul(ra, rb, m_vec, m_len);
    base = gnt_cnt;
    drive_job(2, ra, rb);
    wait_gnt_cnt("restart_gnt", base + 1, 10);
    check("restart_state", 64'(dbg_state), 64'(CLEAR));
    set_req('0);
    wait_drain("restart_drain", 100);
    check("restart_res_vec", 64'(res_vec), 64'(m_vec));
    check("restart_res_len", 64'(res_len), 64'(m_len));

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
